// File: rtl/alert_sched.sv
// alert_sched: shares one piezo buzzer between the anti-theft alarm, the bell
// and the rate-change chirp. Fixed priority with preemption: alarm > bell > chirp.
// Each source plays its own ON/OFF beep pattern. The patterns are timed in ms
// ticks, and the ON phase is gated with a square-wave tone.
//
// Ports:
//   clk    - system clock
//   rst    - synchronous, active-high reset
//   bell   - bell request (level)
//   lock   - lock armed (level)
//   motion - synchronised motion sensor (level)
//   rate   - current rate level 0..3; a change requests rate+1 chirp beeps
//   buzz   - registered tone drive to the buzzer
//   busy   - registered, 1 whenever the scheduler is not idle
//   src    - registered active source: 0 none, 1 chirp, 2 bell, 3 alarm
module alert_sched #(
  parameter int unsigned MS_DIV   = 100000,
  parameter int unsigned TONE_DIV = 25000,
  parameter int unsigned CHIRP_MS = 60,
  parameter int unsigned BELL_MS  = 200,
  parameter int unsigned ALARM_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bell,
  input  logic       lock,
  input  logic       motion,
  input  logic [1:0] rate,
  output logic       buzz,
  output logic       busy,
  output logic [1:0] src
);

  localparam int unsigned NMAX_CB = (CHIRP_MS > BELL_MS) ? CHIRP_MS : BELL_MS;
  localparam int unsigned NMAX    = (NMAX_CB > ALARM_MS) ? NMAX_CB : ALARM_MS;
  localparam int unsigned PRE_W   = (MS_DIV > 1)   ? $clog2(MS_DIV)   : 1;
  localparam int unsigned TONE_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int unsigned CNT_W   = (NMAX > 1)     ? $clog2(NMAX)     : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHIRP = 2'd1,
    ST_BELL  = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  state_t              state_q, state_n;
  logic                alarm_q, alarm_n;
  logic [1:0]          rate_d;
  logic [PRE_W-1:0]    pre_q, pre_n;
  logic [CNT_W-1:0]    ms_q, ms_n;
  logic [1:0]          beep_q, beep_n;
  logic [1:0]          beep_last_q, beep_last_n;
  logic                phase_on_q, phase_on_n;
  logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_n;
  logic                tone_q, tone_n;
  logic                buzz_n;

  logic                chirp_req;
  logic                tick;
  logic                phase_end;
  logic                chirp_done;
  logic [CNT_W-1:0]    last_ms;

  always_comb begin
    state_n     = state_q;
    pre_n       = pre_q;
    ms_n        = ms_q;
    beep_n      = beep_q;
    beep_last_n = beep_last_q;
    phase_on_n  = phase_on_q;
    tone_cnt_n  = tone_cnt_q;
    tone_n      = tone_q;
    last_ms     = '0;

    // Clear beats set. The arbiter uses the next latch value, so an alarm
    // takes over on the edge right after lock & motion.
    alarm_n   = lock ? (alarm_q | motion) : 1'b0;
    chirp_req = (rate != rate_d);

    unique case (state_q)
      ST_CHIRP: last_ms = CNT_W'(CHIRP_MS - 1);
      ST_BELL:  last_ms = CNT_W'(BELL_MS - 1);
      ST_ALARM: last_ms = CNT_W'(ALARM_MS - 1);
      default:  last_ms = '0;
    endcase

    tick       = (pre_q == PRE_W'(MS_DIV - 1));
    phase_end  = tick && (ms_q == last_ms);
    chirp_done = (state_q == ST_CHIRP) && phase_end && !phase_on_q &&
                 (beep_q == beep_last_q);

    if (alarm_n)
      state_n = ST_ALARM;
    else if (bell)
      state_n = ST_BELL;
    else if (chirp_req || ((state_q == ST_CHIRP) && !chirp_done))
      state_n = ST_CHIRP;
    else
      state_n = ST_IDLE;

    // The beep count is latched only when the chirp actually (re)starts.
    // A rate change under bell or alarm is therefore dropped.
    if ((state_n == ST_CHIRP) && chirp_req)
      beep_last_n = rate;

    if (state_n == ST_IDLE) begin
      pre_n      = '0;
      ms_n       = '0;
      beep_n     = '0;
      phase_on_n = 1'b0;
      tone_cnt_n = '0;
      tone_n     = 1'b0;
    end else if ((state_n != state_q) || ((state_n == ST_CHIRP) && chirp_req)) begin
      pre_n      = '0;
      ms_n       = '0;
      beep_n     = '0;
      phase_on_n = 1'b1;
      tone_cnt_n = '0;
      tone_n     = 1'b1;
    end else begin
      if (tone_cnt_q == TONE_W'(TONE_DIV - 1)) begin
        tone_cnt_n = '0;
        tone_n     = !tone_q;
      end else begin
        tone_cnt_n = tone_cnt_q + TONE_W'(1);
      end

      if (tick) begin
        pre_n = '0;
        if (phase_end) begin
          ms_n       = '0;
          phase_on_n = !phase_on_q;
          if (!phase_on_q) begin
            // OFF -> ON: the tone phase restarts, so the pattern inside
            // every ON phase is identical.
            tone_cnt_n = '0;
            tone_n     = 1'b1;
            if (state_q == ST_CHIRP)
              beep_n = beep_q + 2'd1;
          end
        end else begin
          ms_n = ms_q + CNT_W'(1);
        end
      end else begin
        pre_n = pre_q + PRE_W'(1);
      end
    end

    buzz_n = phase_on_n & tone_n & (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    rate_d <= rate;
    if (rst) begin
      state_q     <= ST_IDLE;
      alarm_q     <= 1'b0;
      pre_q       <= '0;
      ms_q        <= '0;
      beep_q      <= '0;
      beep_last_q <= '0;
      phase_on_q  <= 1'b0;
      tone_cnt_q  <= '0;
      tone_q      <= 1'b0;
      buzz        <= 1'b0;
      busy        <= 1'b0;
      src         <= 2'd0;
    end else begin
      state_q     <= state_n;
      alarm_q     <= alarm_n;
      pre_q       <= pre_n;
      ms_q        <= ms_n;
      beep_q      <= beep_n;
      beep_last_q <= beep_last_n;
      phase_on_q  <= phase_on_n;
      tone_cnt_q  <= tone_cnt_n;
      tone_q      <= tone_n;
      buzz        <= buzz_n;
      busy        <= (state_n != ST_IDLE);
      src         <= state_n;
    end
  end

endmodule

// File: tb/tb_alert_sched.sv
// Directed bench for alert_sched with small timing parameters:
// MS_DIV=4, TONE_DIV=2, CHIRP_MS=2, BELL_MS=3, ALARM_MS=1.
// Observed outputs are packed as {src, busy, buzz} and compared each cycle.
module tb_alert_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       bell;
  logic       lock;
  logic       motion;
  logic [1:0] rate;
  logic       buzz;
  logic       busy;
  logic [1:0] src;

  int n_cmp = 0;
  int n_bad = 0;

  alert_sched #(
    .MS_DIV  (4),
    .TONE_DIV(2),
    .CHIRP_MS(2),
    .BELL_MS (3),
    .ALARM_MS(1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bell  (bell),
    .lock  (lock),
    .motion(motion),
    .rate  (rate),
    .buzz  (buzz),
    .busy  (busy),
    .src   (src)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] r);
    rst = 1'b1; rate = r; bell = 1'b0; lock = 1'b0; motion = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    do_reset(2'd0);
    exp = 4'b0000;
    n_cmp++;
    if ({src, busy, buzz} !== exp) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", {src, busy, buzz}, exp);
    end
    step();
    n_cmp++;
    if ({src, busy, buzz} !== exp) begin
      n_bad++;
      $display("FAIL reset_release_idle: got %b want %b", {src, busy, buzz}, exp);
    end
  endtask

  task automatic test_chirp_basic();
    logic [3:0] exp;
    logic       bz;
    do_reset(2'd0);
    rate = 2'd2;
    for (int k = 0; k < 48; k++) begin
      step();
      bz  = ((k % 16) < 8) && ((k % 4) < 2);
      exp = {2'd1, 1'b1, bz};
      n_cmp++;
      if ({src, busy, buzz} !== exp) begin
        n_bad++;
        $display("FAIL chirp3 cycle %0d: got %b want %b", k, {src, busy, buzz}, exp);
      end
    end
    step();
    exp = 4'b0000;
    n_cmp++;
    if ({src, busy, buzz} !== exp) begin
      n_bad++;
      $display("FAIL chirp3_end: got %b want %b", {src, busy, buzz}, exp);
    end
  endtask

  task automatic test_chirp_restart();
    logic [3:0] exp;
    logic       bz;
    do_reset(2'd1);
    rate = 2'd2;
    for (int k = 0; k < 20; k++) begin
      step();
      bz  = ((k % 16) < 8) && ((k % 4) < 2);
      exp = {2'd1, 1'b1, bz};
      n_cmp++;
      if ({src, busy, buzz} !== exp) begin
        n_bad++;
        $display("FAIL restart_pre cycle %0d: got %b want %b", k, {src, busy, buzz}, exp);
      end
    end
    rate = 2'd3;
    for (int k = 0; k < 64; k++) begin
      step();
      bz  = ((k % 16) < 8) && ((k % 4) < 2);
      exp = {2'd1, 1'b1, bz};
      n_cmp++;
      if ({src, busy, buzz} !== exp) begin
        n_bad++;
        $display("FAIL restart_post cycle %0d: got %b want %b", k, {src, busy, buzz}, exp);
      end
    end
    step();
    exp = 4'b0000;
    n_cmp++;
    if ({src, busy, buzz} !== exp) begin
      n_bad++;
      $display("FAIL restart_end: got %b want %b", {src, busy, buzz}, exp);
    end
  endtask

  task automatic test_bell_preempt();
    logic [3:0] exp;
    logic       bz;
    do_reset(2'd0);
    rate = 2'd3;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (src !== 2'd1) begin
        n_bad++;
        $display("FAIL preempt_chirp_src cycle %0d: got %0d want 1", k, src);
      end
    end
    bell = 1'b1;
    for (int k = 0; k < 48; k++) begin
      step();
      bz  = ((k % 24) < 12) && ((k % 4) < 2);
      exp = {2'd2, 1'b1, bz};
      n_cmp++;
      if ({src, busy, buzz} !== exp) begin
        n_bad++;
        $display("FAIL bell cycle %0d: got %b want %b", k, {src, busy, buzz}, exp);
      end
    end
    bell = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      exp = 4'b0000;
      n_cmp++;
      if ({src, busy, buzz} !== exp) begin
        n_bad++;
        $display("FAIL bell_end cycle %0d: got %b want %b", k, {src, busy, buzz}, exp);
      end
    end
  endtask

  task automatic test_alarm_over_bell();
    logic [3:0] exp;
    logic       bz;
    do_reset(2'd0);
    bell = 1'b1;
    repeat (5) step();
    lock = 1'b1;
    step();
    n_cmp++;
    if (src !== 2'd2) begin
      n_bad++;
      $display("FAIL lock_only_src: got %0d want 2", src);
    end
    motion = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      motion = 1'b0;
      bz  = ((k % 8) < 4) && ((k % 4) < 2);
      exp = {2'd3, 1'b1, bz};
      n_cmp++;
      if ({src, busy, buzz} !== exp) begin
        n_bad++;
        $display("FAIL alarm cycle %0d: got %b want %b", k, {src, busy, buzz}, exp);
      end
    end
    lock = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      bz  = ((k % 24) < 12) && ((k % 4) < 2);
      exp = {2'd2, 1'b1, bz};
      n_cmp++;
      if ({src, busy, buzz} !== exp) begin
        n_bad++;
        $display("FAIL alarm_to_bell cycle %0d: got %b want %b", k, {src, busy, buzz}, exp);
      end
    end
    bell = 1'b0;
    step();
    n_cmp++;
    if ({src, busy, buzz} !== 4'b0000) begin
      n_bad++;
      $display("FAIL alarm_bell_end: got %b want 0000", {src, busy, buzz});
    end
  endtask

  task automatic test_latch_edges();
    do_reset(2'd0);
    lock = 1'b0;
    motion = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if ({src, busy, buzz} !== 4'b0000) begin
        n_bad++;
        $display("FAIL unlocked_motion cycle %0d: got %b want 0000", k, {src, busy, buzz});
      end
    end
    motion = 1'b0;
    step();
    lock = 1'b1;
    motion = 1'b1;
    step();
    n_cmp++;
    if ({src, busy, buzz} !== 4'b1111) begin
      n_bad++;
      $display("FAIL same_cycle_latch: got %b want 1111", {src, busy, buzz});
    end
    motion = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (src !== 2'd3) begin
        n_bad++;
        $display("FAIL latch_hold cycle %0d: got %0d want 3", k, src);
      end
    end
    lock = 1'b0;
    step();
    n_cmp++;
    if ({src, busy, buzz} !== 4'b0000) begin
      n_bad++;
      $display("FAIL latch_clear: got %b want 0000", {src, busy, buzz});
    end
  endtask

  task automatic test_reset_mid_alarm();
    do_reset(2'd0);
    lock = 1'b1;
    motion = 1'b1;
    step();
    motion = 1'b0;
    repeat (5) step();
    n_cmp++;
    if ({src, busy} !== 3'b111) begin
      n_bad++;
      $display("FAIL mid_alarm_active: got %b want 111", {src, busy});
    end
    rst = 1'b1;
    rate = 2'd1;
    step();
    n_cmp++;
    if ({src, busy, buzz} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_mid_alarm: got %b want 0000", {src, busy, buzz});
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if ({src, busy, buzz} !== 4'b0000) begin
        n_bad++;
        $display("FAIL post_reset_idle cycle %0d: got %b want 0000", k, {src, busy, buzz});
      end
    end
  endtask

  initial begin
    rst = 1'b1; bell = 1'b0; lock = 1'b0; motion = 1'b0; rate = 2'd0;
    test_reset();
    test_chirp_basic();
    test_chirp_restart();
    test_bell_preempt();
    test_alarm_over_bell();
    test_latch_edges();
    test_reset_mid_alarm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alert_sched.md
Name: alert_sched

Overview:
- Single piezo buzzer shared by three requesters: anti-theft alarm, bell and rate-change chirp.
- Sits after the button controller. Consumes its bell, lock and rate outputs plus the frame motion sensor.
- Fixed-priority arbiter with preemption: alarm > bell > chirp.
- Each source has its own on/off beep pattern, timed in milliseconds and gated with a square-wave tone.

Parameters:
- MS_DIV, 100000: clk cycles per 1 ms tick (100 MHz clock).
- TONE_DIV, 25000: clk cycles per tone half-period (2 kHz tone).
- CHIRP_MS, 60: chirp beep on time and gap time, in ms.
- BELL_MS, 200: bell on time and off time, in ms.
- ALARM_MS, 100: alarm on time and off time, in ms.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- bell, in, 1: level. Bell requested while 1.
- lock, in, 1: level. Lock armed while 1.
- motion, in, 1: level from motion sensor, already synchronised.
- rate, in, 2: current rate level, 0..3.
- buzz, out, 1: tone drive to the buzzer.
- busy, out, 1: 1 whenever state is not IDLE.
- src, out, 2: active source. 0 = none, 1 = chirp, 2 = bell, 3 = alarm.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; buzz = busy = 0; src = 0.
  - All counters = 0; alarm latch = 0.
  - rate_d loads the current rate, so no chirp follows reset.
- Alarm latch:
  - Sets on any cycle with lock & motion.
  - Clears on any cycle with lock = 0; clear has priority over set.
- Chirp request:
  - Raised when rate != rate_d (rate_d is a 1-cycle registered copy).
  - Beep count = new rate + 1, i.e. 1..4 beeps.
  - A rate change while in CHIRP restarts CHIRP at phase ON, beep 1, with the new count.
  - A rate change while in BELL or ALARM is dropped (no queued chirp).
- States: IDLE, CHIRP, BELL, ALARM. Outputs are registered; src encodes the state directly.
- Next-state priority, evaluated every cycle:
  - alarm latch → ALARM.
  - else bell → BELL.
  - else chirp request, or CHIRP still running → CHIRP.
  - else → IDLE.
  - A higher-priority request preempts the current state on the next cycle. A preempted chirp is discarded.
  - If BELL ends (bell = 0) or ALARM ends (latch = 0), the FSM returns to IDLE, or to a lower source that is still requesting.
- Pattern timing:
  - On every state entry, the ms prescaler, ms counter, beep counter and tone divider restart, and phase = ON.
  - ON lasts N ms ticks, then OFF lasts N ms ticks, alternating. N is CHIRP_MS, BELL_MS or ALARM_MS for the active state.
  - Each phase lasts exactly N×MS_DIV cycles.
- CHIRP end:
  - After the OFF phase of the last beep, return to IDLE.
  - busy stays 1 through that final gap.
- BELL and ALARM alternate ON/OFF indefinitely while requested.
- Tone:
  - tone_q is set to 1 at the start of each ON phase.
  - tone_q toggles every TONE_DIV cycles.
  - buzz = (phase == ON) & tone_q & (state != IDLE), registered.
  - buzz is 0 throughout OFF phases and IDLE.
- Reset asserted mid-pattern: at the next edge, all outputs go to 0 and the alarm latch clears.
- Counter widths: sized from the parameters with $clog2; no wrap occurs within a phase.

Test Plan:
All scenarios use bench parameters MS_DIV=4, TONE_DIV=2, CHIRP_MS=2, BELL_MS=3, ALARM_MS=1.
1. Rate steps 0→2 -> src=1 for 3 beeps.
   - Each beep: buzz toggles 1,1,0,0,… for 8 cycles, then is 0 for 8 cycles.
   - busy=1 for 48 cycles, then src=0.
2. Rate steps 1→2, then 2→3 during beep 2 -> CHIRP restarts; 4 full beeps (64 cycles) follow the second change.
3. bell=1 during a chirp -> src=2 the next cycle with the chirp discarded.
   - Pattern: 12 cycles ON, 12 cycles OFF, repeating.
   - bell=0 -> IDLE the next cycle.
4. lock=1, 1-cycle motion pulse while bell=1 -> src=3 the next cycle; 4 cycles ON / 4 cycles OFF repeating.
   - lock=0 -> src=2 (bell still held).
5. lock=0 with motion=1 -> no alarm.
   - lock and motion rising in the same cycle -> alarm latches.
6. rst=1 mid-alarm -> buzz=0, busy=0, src=0 the next cycle.
   - After release with lock=1 and motion=0: stays IDLE, and no chirp from the stable rate.
